// File: rtl/lane_hit_judge_if.sv
// lane_hit_judge_if
// Groups the note/button inputs and the score outputs of lane_hit_judge.
//   button      : per-lane debounced button level
//   offset      : shared sub-beat position
//   shift_tick  : one-cycle row-advance pulse
//   node_bus    : per-lane note-row bits, lane i at [i*NODE_W +: NODE_W]
//   score       : per-lane 2-bit grade, lane i at [2i +: 2]
//   score_valid : per-lane one-cycle strobe
// master drives the inputs (game side), slave is the judge.
interface lane_hit_judge_if #(
    parameter int LANES  = 4,
    parameter int NODE_W = 4,
    parameter int OFF_W  = 4
) ();
    logic [LANES-1:0]        button;
    logic [OFF_W-1:0]        offset;
    logic                    shift_tick;
    logic [LANES*NODE_W-1:0] node_bus;
    logic [2*LANES-1:0]      score;
    logic [LANES-1:0]        score_valid;

    modport master (
        output button, offset, shift_tick, node_bus,
        input  score, score_valid
    );

    modport slave (
        input  button, offset, shift_tick, node_bus,
        output score, score_valid
    );
endinterface

// File: rtl/lane_hit_judge.sv
// lane_hit_judge
// Grades each note once per lane: 11 perfect, 10 late, 01 early, 00 miss.
// Result appears on score/score_valid one cycle after the press or tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : lane_hit_judge_if.slave (button, offset, shift_tick, node_bus in;
//          score, score_valid out)
//   combo, combo_max : present only when COMBO_COUNT_EN is defined; running
//          hit streak (saturating at 255) and its maximum.
//
// Lane FSM:
//   state    | meaning
//   IDLE     | no note waiting in the hit row
//   ARMED    | note in the hit row, waiting for a press or the tick
//   DONE     | note graded, presses ignored until the tick
module lane_hit_judge #(
    parameter int LANES   = 4,
    parameter int NODE_W  = 4,
    parameter int HIT_ROW = 1,
    parameter int OFF_W   = 4,
    parameter int PERF_LO = 2,
    parameter int PERF_HI = 4,
    parameter int LATE_HI = 6
) (
    input  logic              clk,
    input  logic              rst,
    lane_hit_judge_if.slave   bus
`ifdef COMBO_COUNT_EN
    ,
    output logic [7:0]        combo,
    output logic [7:0]        combo_max
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [OFF_W-1:0] PERF_LO_V = OFF_W'(PERF_LO);
    localparam logic [OFF_W-1:0] PERF_HI_V = OFF_W'(PERF_HI);
    localparam logic [OFF_W-1:0] LATE_HI_V = OFF_W'(LATE_HI);

    logic [LANES-1:0]   btn_q;
    logic [LANES-1:0]   press;
    logic [1:0]         state [LANES];
    logic [2*LANES-1:0] score_q;
    logic [LANES-1:0]   valid_q;
    logic [1:0]         grade;
    logic               in_win;

    assign press           = bus.button & ~btn_q;
    assign bus.score       = score_q;
    assign bus.score_valid = valid_q;

    // offset is shared, so one grade serves every lane.
    always_comb begin
        grade  = 2'b00;
        in_win = 1'b1;
        if (bus.offset >= PERF_LO_V && bus.offset <= PERF_HI_V) begin
            grade = 2'b11;
        end else if (bus.offset > PERF_HI_V && bus.offset <= LATE_HI_V) begin
            grade = 2'b10;
        end else if (bus.offset < PERF_LO_V) begin
            grade = 2'b01;
        end else begin
            in_win = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= '0;
            score_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                state[i] <= ST_IDLE;
            end
        end else begin
            btn_q <= bus.button;
            for (int i = 0; i < LANES; i++) begin
                valid_q[i] <= 1'b0;
                case (state[i])
                    ST_IDLE: begin
                        // node_bus is stale during the tick cycle
                        if (bus.node_bus[i*NODE_W+HIT_ROW] && !bus.shift_tick) begin
                            state[i] <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (press[i] && in_win) begin
                            score_q[2*i +: 2] <= grade;
                            valid_q[i]        <= 1'b1;
                            // a press coinciding with the tick still wins,
                            // but the note has already left the hit row
                            state[i]          <= bus.shift_tick ? ST_IDLE : ST_DONE;
                        end else if (bus.shift_tick) begin
                            score_q[2*i +: 2] <= 2'b00;
                            valid_q[i]        <= 1'b1;
                            state[i]          <= ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        if (bus.shift_tick) begin
                            state[i] <= ST_IDLE;
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef COMBO_COUNT_EN
    logic [7:0] hit_cnt;
    logic       miss_any;
    logic [8:0] combo_sum;

    always_comb begin
        hit_cnt  = 8'd0;
        miss_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (valid_q[i]) begin
                if (score_q[2*i +: 2] == 2'b00) begin
                    miss_any = 1'b1;
                end else begin
                    hit_cnt = hit_cnt + 8'd1;
                end
            end
        end
        combo_sum = {1'b0, combo} + {1'b0, hit_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            combo     <= 8'd0;
            combo_max <= 8'd0;
        end else begin
            if (miss_any) begin
                combo <= 8'd0;
            end else if (combo_sum[8]) begin
                combo <= 8'hFF;
            end else begin
                combo <= combo_sum[7:0];
            end
            if (combo > combo_max) begin
                combo_max <= combo;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lane_hit_judge.sv
module tb_lane_hit_judge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    lane_hit_judge_if #(.LANES(4), .NODE_W(4), .OFF_W(4)) bus ();

`ifdef COMBO_COUNT_EN
    logic [7:0] combo;
    logic [7:0] combo_max;
`endif

    lane_hit_judge #(
        .LANES(4), .NODE_W(4), .HIT_ROW(1), .OFF_W(4),
        .PERF_LO(2), .PERF_HI(4), .LATE_HI(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef COMBO_COUNT_EN
        ,
        .combo     (combo),
        .combo_max (combo_max)
`endif
    );

    // hit-row bit of each selected lane
    function automatic logic [15:0] notes(input logic [3:0] lanes);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) n[i*4+1] = 1'b1;
        end
        return n;
    endfunction

    // inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // arm the lanes, press them together, then tick the note away
    task automatic hit_lanes(input logic [3:0] lanes, input logic [3:0] off);
        bus.node_bus   = notes(lanes);
        bus.shift_tick = 1'b0;
        bus.button     = 4'b0000;
        step();
        bus.button = lanes;
        bus.offset = off;
        step();
        bus.button     = 4'b0000;
        bus.shift_tick = 1'b1;
        step();
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        step();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.button     = 4'b1111;
        bus.node_bus   = notes(4'b1111);
        bus.offset     = 4'd3;
        bus.shift_tick = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            vec_cnt++; if (bus.score !== 8'h00) begin err_cnt++; $display("FAIL reset_score got=%h exp=00", bus.score); end
            vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0000", bus.score_valid); end
        end
`ifdef COMBO_COUNT_EN
        vec_cnt++; if (combo !== 8'd0 || combo_max !== 8'd0) begin err_cnt++; $display("FAIL reset_combo got=%0d/%0d exp=0/0", combo, combo_max); end
`endif
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL held_no_strobe got=%b exp=0000", bus.score_valid); end
        end
        // lanes are armed now; reset must discard them without a miss
        rst = 1'b1;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL reset_midnote got=%b exp=0000", bus.score_valid); end
        rst            = 1'b0;
        bus.button     = 4'b0000;
        bus.node_bus   = '0;
        bus.shift_tick = 1'b1;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL reset_nomiss got=%b exp=0000", bus.score_valid); end
        bus.shift_tick = 1'b0;
        step();
    endtask

    task automatic test_perfect();
        bus.node_bus = notes(4'b0001);
        bus.offset   = 4'd3;
        step();
        bus.button = 4'b0001;
        step();
        vec_cnt++; if (bus.score[1:0] !== 2'b11) begin err_cnt++; $display("FAIL perf_score got=%b exp=11", bus.score[1:0]); end
        vec_cnt++; if (bus.score_valid !== 4'b0001) begin err_cnt++; $display("FAIL perf_valid got=%b exp=0001", bus.score_valid); end
        bus.button = 4'b0000;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL perf_pulse got=%b exp=0000", bus.score_valid); end
        vec_cnt++; if (bus.score[1:0] !== 2'b11) begin err_cnt++; $display("FAIL perf_hold got=%b exp=11", bus.score[1:0]); end
        bus.button = 4'b0001;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL perf_second_press got=%b exp=0000", bus.score_valid); end
        bus.button     = 4'b0000;
        bus.shift_tick = 1'b1;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL done_tick got=%b exp=0000", bus.score_valid); end
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        step();
    endtask

    task automatic test_windows();
        bus.node_bus = notes(4'b1110);
        step();
        bus.offset = 4'd1;
        bus.button = 4'b0010;
        step();
        vec_cnt++; if (bus.score[3:2] !== 2'b01) begin err_cnt++; $display("FAIL early_score got=%b exp=01", bus.score[3:2]); end
        vec_cnt++; if (bus.score_valid !== 4'b0010) begin err_cnt++; $display("FAIL early_valid got=%b exp=0010", bus.score_valid); end
        bus.offset = 4'd6;
        bus.button = 4'b0100;
        step();
        vec_cnt++; if (bus.score[5:4] !== 2'b10) begin err_cnt++; $display("FAIL late_score got=%b exp=10", bus.score[5:4]); end
        vec_cnt++; if (bus.score_valid !== 4'b0100) begin err_cnt++; $display("FAIL late_valid got=%b exp=0100", bus.score_valid); end
        bus.offset = 4'd9;
        bus.button = 4'b1000;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL outwin_valid got=%b exp=0000", bus.score_valid); end
        bus.button     = 4'b0000;
        bus.shift_tick = 1'b1;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b1000) begin err_cnt++; $display("FAIL outwin_miss_valid got=%b exp=1000", bus.score_valid); end
        vec_cnt++; if (bus.score[7:6] !== 2'b00) begin err_cnt++; $display("FAIL outwin_miss_score got=%b exp=00", bus.score[7:6]); end
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        step();
    endtask

    task automatic test_miss();
        bus.node_bus = notes(4'b0100);
        step();
        bus.shift_tick = 1'b1;
        step();
        vec_cnt++; if (bus.score[5:4] !== 2'b00) begin err_cnt++; $display("FAIL miss_score got=%b exp=00", bus.score[5:4]); end
        vec_cnt++; if (bus.score_valid !== 4'b0100) begin err_cnt++; $display("FAIL miss_valid got=%b exp=0100", bus.score_valid); end
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL miss_pulse got=%b exp=0000", bus.score_valid); end
    endtask

    task automatic test_collision();
        bus.node_bus = notes(4'b0001);
        step();
        bus.offset     = 4'd4;
        bus.button     = 4'b0001;
        bus.shift_tick = 1'b1;
        step();
        vec_cnt++; if (bus.score[1:0] !== 2'b11) begin err_cnt++; $display("FAIL coll_score got=%b exp=11", bus.score[1:0]); end
        vec_cnt++; if (bus.score_valid !== 4'b0001) begin err_cnt++; $display("FAIL coll_valid got=%b exp=0001", bus.score_valid); end
        bus.button     = 4'b0000;
        bus.shift_tick = 1'b0;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL coll_nomiss got=%b exp=0000", bus.score_valid); end
        // lane went back to IDLE and re-armed on the still-present note
        bus.offset = 4'd1;
        bus.button = 4'b0001;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0001) begin err_cnt++; $display("FAIL coll_rearm_valid got=%b exp=0001", bus.score_valid); end
        vec_cnt++; if (bus.score[1:0] !== 2'b01) begin err_cnt++; $display("FAIL coll_rearm_score got=%b exp=01", bus.score[1:0]); end
        bus.button     = 4'b0000;
        bus.shift_tick = 1'b1;
        bus.node_bus   = '0;
        step();
        bus.shift_tick = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bus.node_bus = notes(4'b0110);
        step();
        bus.offset = 4'd2;
        bus.button = 4'b0110;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0110) begin err_cnt++; $display("FAIL b2b_valid got=%b exp=0110", bus.score_valid); end
        vec_cnt++; if (bus.score[5:2] !== 4'b1111) begin err_cnt++; $display("FAIL b2b_score got=%b exp=1111", bus.score[5:2]); end
        bus.button     = 4'b0000;
        bus.shift_tick = 1'b1;
        step();
        vec_cnt++; if (bus.score_valid !== 4'b0000) begin err_cnt++; $display("FAIL b2b_tick got=%b exp=0000", bus.score_valid); end
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        step();
    endtask

`ifdef COMBO_COUNT_EN
    task automatic test_combo();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) hit_lanes(4'b0001, 4'd3);
        hit_lanes(4'b0110, 4'd3);
        vec_cnt++; if (combo !== 8'd5) begin err_cnt++; $display("FAIL combo_5 got=%0d exp=5", combo); end
        vec_cnt++; if (combo_max !== 8'd5) begin err_cnt++; $display("FAIL combo_max_5 got=%0d exp=5", combo_max); end
        bus.node_bus = notes(4'b0100);
        step();
        bus.shift_tick = 1'b1;
        step();
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        step();
        step();
        vec_cnt++; if (combo !== 8'd0) begin err_cnt++; $display("FAIL combo_miss got=%0d exp=0", combo); end
        vec_cnt++; if (combo_max !== 8'd5) begin err_cnt++; $display("FAIL combo_max_keep got=%0d exp=5", combo_max); end
        for (int k = 0; k < 65; k++) hit_lanes(4'b1111, 4'd3);
        vec_cnt++; if (combo !== 8'd255) begin err_cnt++; $display("FAIL combo_sat got=%0d exp=255", combo); end
        vec_cnt++; if (combo_max !== 8'd255) begin err_cnt++; $display("FAIL combo_max_sat got=%0d exp=255", combo_max); end
    endtask
`endif

    initial begin
        bus.button     = '0;
        bus.offset     = '0;
        bus.shift_tick = 1'b0;
        bus.node_bus   = '0;
        #1;
        test_reset();
        test_perfect();
        test_windows();
        test_miss();
        test_collision();
        test_back_to_back();
`ifdef COMBO_COUNT_EN
        test_combo();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
